// File: rtl/morse_disp_pkg.sv
// Shared types, code constants and the character-to-segment table for the
// Morse display buffer.
package morse_disp_pkg;

    localparam int CODE_W   = 6;
    localparam int N_DIGITS = 8;
    localparam int SEG_W    = 8 * N_DIGITS;

    typedef logic [CODE_W-1:0] code_t;
    typedef logic [7:0]        seg_t;

    localparam code_t CODE_BLANK = 6'd0;
    localparam code_t CODE_A     = 6'd1;
    localparam code_t CODE_DIG0  = 6'd27;
    localparam code_t CODE_DASH  = 6'd37;

    localparam seg_t SEG_BLANK = 8'h00;
    localparam seg_t SEG_DASH  = 8'h02;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_CLR,
        CMD_BKSP,
        CMD_PUSH
    } cmd_e;

    // clr outranks bksp, which outranks char_valid; losers are dropped.
    function automatic cmd_e decode_cmd(input logic clr, input logic bksp,
                                        input logic char_valid);
        if (clr)             return CMD_CLR;
        else if (bksp)       return CMD_BKSP;
        else if (char_valid) return CMD_PUSH;
        else                 return CMD_NONE;
    endfunction

    // Pattern bits {a,b,c,d,e,f,g,dp}; dp is always 0 here. Letters that have
    // no clean 7-segment form use the usual lowercase or nearest shape.
    function automatic seg_t char_to_seg(input code_t code);
        case (code)
            6'd0:  return SEG_BLANK;
            6'd1:  return 8'hEE;  // A
            6'd2:  return 8'h3E;  // b
            6'd3:  return 8'h9C;  // C
            6'd4:  return 8'h7A;  // d
            6'd5:  return 8'h9E;  // E
            6'd6:  return 8'h8E;  // F
            6'd7:  return 8'hBC;  // G
            6'd8:  return 8'h6E;  // H
            6'd9:  return 8'h0C;  // I
            6'd10: return 8'h78;  // J
            6'd11: return 8'hAE;  // K
            6'd12: return 8'h1C;  // L
            6'd13: return 8'hA8;  // M
            6'd14: return 8'h2A;  // n
            6'd15: return 8'h3A;  // o
            6'd16: return 8'hCE;  // P
            6'd17: return 8'hE6;  // q
            6'd18: return 8'h0A;  // r
            6'd19: return 8'hB6;  // S
            6'd20: return 8'h1E;  // t
            6'd21: return 8'h7C;  // U
            6'd22: return 8'h38;  // v
            6'd23: return 8'h54;  // W
            6'd24: return 8'h6E;  // X
            6'd25: return 8'h76;  // y
            6'd26: return 8'hDA;  // Z
            6'd27: return 8'hFC;  // 0
            6'd28: return 8'h60;  // 1
            6'd29: return 8'hDA;  // 2
            6'd30: return 8'hF2;  // 3
            6'd31: return 8'h66;  // 4
            6'd32: return 8'hB6;  // 5
            6'd33: return 8'hBE;  // 6
            6'd34: return 8'hE0;  // 7
            6'd35: return 8'hFE;  // 8
            6'd36: return 8'hF6;  // 9
            default: return SEG_DASH;  // 37 and every illegal code
        endcase
    endfunction

endpackage

// File: rtl/morse_char_to_seg.sv
// Combinational decode of one character code to its segment pattern (dp = 0).
module morse_char_to_seg
    import morse_disp_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [7:0]        seg
);

    assign seg = char_to_seg(code);

endmodule

// File: rtl/morse_disp_buf.sv
// Eight-character right-aligned display buffer with backspace/clear and a
// blinking rightmost dp while a symbol is being keyed.
module morse_disp_buf
    import morse_disp_pkg::*;
#(
    parameter int BLINK_CYCLES = 50_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              char_valid,
    input  logic [CODE_W-1:0] char_code,
    input  logic              bksp,
    input  logic              clr,
    input  logic              keying,
    output logic [SEG_W-1:0]  seg_data,
    output logic [3:0]        char_count,
    output logic              full
);

    localparam int             CNT_W    = $clog2(BLINK_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_CYCLES - 1);
    localparam logic [3:0]     COUNT_MAX = 4'(N_DIGITS);

    code_t            chars_q [N_DIGITS];
    logic [3:0]       count_q;
    logic [CNT_W-1:0] blink_cnt_q;
    logic             phase_q;
    cmd_e             cmd;
    seg_t             pats [N_DIGITS];
    logic [SEG_W-1:0] seg_next;

    assign cmd = decode_cmd(clr, bksp, char_valid);

    // NOTE: the character array is reset explicitly because a blank display
    // after reset depends on every slot holding CODE_BLANK, not on power-up.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_DIGITS; i++) chars_q[i] <= CODE_BLANK;
            count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments make every shift read the
            // pre-edge neighbour, so the loop order does not matter.
            case (cmd)
                CMD_CLR: begin
                    for (int i = 0; i < N_DIGITS; i++) chars_q[i] <= CODE_BLANK;
                    count_q <= '0;
                end
                CMD_BKSP: begin
                    if (count_q != 4'd0) begin
                        for (int i = 1; i < N_DIGITS; i++) chars_q[i] <= chars_q[i-1];
                        chars_q[0] <= CODE_BLANK;
                        count_q    <= count_q - 4'd1;
                    end
                end
                CMD_PUSH: begin
                    for (int i = 0; i < N_DIGITS - 1; i++) chars_q[i] <= chars_q[i+1];
                    chars_q[N_DIGITS-1] <= char_code;
                    if (count_q != COUNT_MAX) count_q <= count_q + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Free-running blink timebase; keying only gates the dp, never the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else if (blink_cnt_q == CNT_LAST) begin
            blink_cnt_q <= '0;
            phase_q     <= ~phase_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
        morse_char_to_seg u_dec (
            .code (chars_q[g]),
            .seg  (pats[g])
        );
    end

    // NOTE: seg_next gets a full default first so no bit can infer a latch.
    always_comb begin
        seg_next = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            seg_next[SEG_W-1-8*i -: 8] = pats[i];
        end
        seg_next[0] = keying & phase_q;
    end

    always_ff @(posedge clk) begin
        if (rst) seg_data <= '0;
        else     seg_data <= seg_next;
    end

    assign char_count = count_q;
    assign full       = (count_q == COUNT_MAX);

endmodule

// File: tb/tb_morse_disp_buf.sv
// Directed bench for morse_disp_buf: queue-based display model checked every
// cycle, plus hand-computed literal expectations.
module tb_morse_disp_buf;

    localparam int BLINK = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        char_valid = 1'b0;
    logic [5:0]  char_code = '0;
    logic        bksp = 1'b0;
    logic        clr = 1'b0;
    logic        keying = 1'b0;
    logic [63:0] seg_data;
    logic [3:0]  char_count;
    logic        full;

    int n_cmp = 0;
    int n_bad = 0;

    morse_disp_buf #(.BLINK_CYCLES(BLINK)) dut (
        .clk        (clk),
        .rst        (rst),
        .char_valid (char_valid),
        .char_code  (char_code),
        .bksp       (bksp),
        .clr        (clr),
        .keying     (keying),
        .seg_data   (seg_data),
        .char_count (char_count),
        .full       (full)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h, wanted %h at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic logic [7:0] seg_of(input int code);
        case (code)
            0: return 8'h00;
            1: return 8'hEE;   2: return 8'h3E;   3: return 8'h9C;   4: return 8'h7A;
            5: return 8'h9E;   6: return 8'h8E;   7: return 8'hBC;   8: return 8'h6E;
            9: return 8'h0C;  10: return 8'h78;  11: return 8'hAE;  12: return 8'h1C;
           13: return 8'hA8;  14: return 8'h2A;  15: return 8'h3A;  16: return 8'hCE;
           17: return 8'hE6;  18: return 8'h0A;  19: return 8'hB6;  20: return 8'h1E;
           21: return 8'h7C;  22: return 8'h38;  23: return 8'h54;  24: return 8'h6E;
           25: return 8'h76;  26: return 8'hDA;  27: return 8'hFC;  28: return 8'h60;
           29: return 8'hDA;  30: return 8'hF2;  31: return 8'h66;  32: return 8'hB6;
           33: return 8'hBE;  34: return 8'hE0;  35: return 8'hFE;  36: return 8'hF6;
           default: return 8'h02;
        endcase
    endfunction

    // Model: the held characters as a queue (oldest first), edges since reset,
    // and the pattern the display register must show after the latest edge.
    int          q[$];
    int          edges = 0;
    logic [63:0] exp_seg = '0;
    bit          model_valid = 0;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            edges       = 0;
            exp_seg     = '0;
            model_valid = 1;
        end else begin
            // Display shows the queue as it stood before this edge.
            exp_seg = '0;
            for (int d = 0; d < 8; d++) begin
                int idx;
                idx = d - (8 - q.size());
                if (idx >= 0) exp_seg[63-8*d -: 8] = seg_of(q[idx]);
            end
            exp_seg[0] = keying & (((edges / BLINK) % 2) == 1);
            edges++;
            if (clr) q.delete();
            else if (bksp) begin
                if (q.size() > 0) void'(q.pop_back());
            end else if (char_valid) begin
                q.push_back(int'(char_code));
                if (q.size() > 8) void'(q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("model_seg", seg_data, exp_seg);
            check("model_count", 64'(char_count), 64'(q.size()));
            check("model_full", 64'(full), 64'(q.size() == 8));
        end
    end

    task automatic send(input int code);
        char_valid = 1'b1;
        char_code  = 6'(code);
        @(negedge clk);
        char_valid = 1'b0;
    endtask

    task automatic pulse(input logic c, input logic b, input logic v, input int code);
        clr = c; bksp = b; char_valid = v; char_code = 6'(code);
        @(negedge clk);
        clr = 1'b0; bksp = 1'b0; char_valid = 1'b0;
    endtask

    logic v[12];

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_seg", seg_data, 64'h0);
        check("idle_count", 64'(char_count), 64'd0);
        check("idle_full", 64'(full), 64'd0);

        send(1); send(5); send(27);
        check("abc_count", 64'(char_count), 64'd3);
        @(negedge clk);
        check("abc_low", 64'(seg_data[23:0]), 64'hEE9EFC);
        check("abc_high", 64'(seg_data[63:24]), 64'h0);

        pulse(1'b1, 1'b0, 1'b0, 0);
        for (int c = 1; c <= 10; c++) send(c);
        check("fill_full", 64'(full), 64'd1);
        check("fill_count", 64'(char_count), 64'd8);
        @(negedge clk);
        check("fill_digit0_C", 64'(seg_data[63:56]), 64'h9C);
        check("fill_digit7_J", 64'(seg_data[7:0]), 64'h78);

        pulse(1'b0, 1'b1, 1'b0, 0);
        check("bksp_count", 64'(char_count), 64'd7);
        @(negedge clk);
        check("bksp_digit0", 64'(seg_data[63:56]), 64'h00);
        check("bksp_digit7_I", 64'(seg_data[7:0]), 64'h0C);

        pulse(1'b0, 1'b1, 1'b1, 20);
        check("bksp_over_push_count", 64'(char_count), 64'd6);
        @(negedge clk);
        check("bksp_over_push_d7", 64'(seg_data[7:0]), 64'h6E);

        pulse(1'b1, 1'b1, 1'b0, 0);
        check("clr_count", 64'(char_count), 64'd0);
        @(negedge clk);
        check("clr_seg", seg_data, 64'h0);

        pulse(1'b0, 1'b1, 1'b0, 0);
        @(negedge clk);
        check("bksp_empty_count", 64'(char_count), 64'd0);
        check("bksp_empty_seg", seg_data, 64'h0);

        send(45);
        @(negedge clk);
        check("illegal_dash", 64'(seg_data[7:0]), 64'h02);

        keying = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            v[i] = seg_data[0];
        end
        for (int i = 0; i < 8; i++) check("blink_period", 64'(v[i] ^ v[i+4]), 64'd1);
        keying = 1'b0;
        @(negedge clk);
        check("keying_off_dp", 64'(seg_data[0]), 64'd0);

        keying = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1; char_valid = 1'b1; char_code = 6'd5;
        @(negedge clk);
        check("rst_seg", seg_data, 64'h0);
        check("rst_count", 64'(char_count), 64'd0);
        check("rst_full", 64'(full), 64'd0);
        rst = 1'b0; char_valid = 1'b0; keying = 1'b0;
        @(negedge clk);
        check("rst_not_stored", 64'(char_count), 64'd0);
        check("rst_seg_after", seg_data, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/morse_disp_buf.md
# morse_disp_buf

Eight-character display buffer between the Morse symbol decoder and the 8-digit seven-segment scanner. Accepts decoded character codes one at a time and keeps the last eight right-aligned, newest on the rightmost digit. Supports backspace and clear. Drives the scanner's 64-bit segment-pattern input, and blinks the rightmost decimal point while a symbol is being keyed.

## Interface
- `BLINK_CYCLES`, default 50_000_000: clock cycles per blink half-period (0.5 s at 100 MHz); must be ≥ 2.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `char_valid` in 1: single-cycle strobe; `char_code` is valid this cycle.
- `char_code` in 6: character code (encoding below).
- `bksp` in 1: single-cycle strobe; delete newest character.
- `clr` in 1: single-cycle strobe; blank whole display.
- `keying` in 1: level; high while the decoder is mid-symbol.
- `seg_data` out 64: segment patterns. [63:56] is digit 0 (leftmost) … [7:0] is digit 7 (rightmost).
- `char_count` out 4: characters held, 0..8.
- `full` out 1: `char_count == 8`.

## Operation
- Character codes:
  - 0 = blank.
  - 1–26 = A–Z.
  - 27–36 = digits 0–9.
  - 37 = '-' (decode error).
  - 38–63 are illegal and are displayed as '-'.
- Pattern byte: bit7..bit0 = {a,b,c,d,e,f,g,dp}, 1 = segment lit.
  - Blank = 8'h00, '-' = 8'h02, A = 8'hEE, E = 8'h9E, 0 = 8'hFC, 1 = 8'h60.
  - The full A–Z/0–9 table lives in the package.
- State: `buf[0..7]` of 6-bit codes (index 7 = rightmost), `count` (4 bits), blink counter, blink phase.
- Command priority per cycle: `clr` > `bksp` > `char_valid`. Lower-priority strobes in the same cycle are dropped.
- `clr`: all `buf` = 0, `count` = 0.
- `bksp`:
  - `buf[i]` ← `buf[i-1]` for i = 7..1, `buf[0]` ← 0.
  - `count` ← `count` − 1, saturating at 0.
  - With `count` = 0 the buffer is unchanged.
- `char_valid`:
  - `buf[i]` ← `buf[i+1]` for i = 0..6, `buf[7]` ← `char_code`.
  - `count` ← min(`count` + 1, 8).
  - When full, the oldest character (`buf[0]`) is discarded.
  - Code 0 is accepted and counted (a word space).
- Blink:
  - The counter runs freely from 0 to BLINK_CYCLES−1, then wraps.
  - The phase toggles on each wrap.
  - dp of digit 7 = `keying` & phase. All other dp bits are 0.
  - `keying` does not reset the counter.
- `seg_data` is registered: encoding of `buf` plus the dp overlay.

## Timing
- Reset values: `buf` all 0, `count` 0, `seg_data` 64'h0, `char_count` 0, `full` 0, blink counter 0, phase 0.
- Command strobe sampled at edge N:
  - `buf`, `char_count` and `full` update at edge N.
  - `seg_data` reflects it after edge N+1 (2-cycle strobe-to-pattern latency).
- Blink phase toggles at the edge where the counter wraps BLINK_CYCLES−1 → 0. The dp follows one edge later through the `seg_data` register.
- `keying` level to dp: one edge.
- `rst` asserted mid-operation: every state and output returns to its reset value at that edge, and strobes in the same cycle are ignored.
- Back-to-back strobes on consecutive cycles are each applied in full; there is no busy/ready.

## Structure
- Package `morse_disp_pkg`:
  - `CODE_W` = 6, `N_DIGITS` = 8.
  - Code constants `CODE_BLANK`, `CODE_A`, `CODE_DIG0`, `CODE_DASH`.
  - `SEG_BLANK`, `SEG_DASH`, and the `char_to_seg` table/function.
- One combinational sub-module, `morse_char_to_seg` (6-bit code → 8-bit pattern, dp = 0), instantiated 8 times.
- The buffer/count/blink logic is in the top module.

## Test plan
- Reset, then idle 10 cycles → `seg_data` = 0, `char_count` = 0, `full` = 0.
- Strobe codes 1, 5, 27 on consecutive cycles → after 2 edges `seg_data[23:0]` = 24'hEE9EFC, upper bytes 0, `char_count` = 3.
- Strobe 10 characters with codes 1..10 → `full` = 1, `char_count` = 8, `buf` holds codes 3..10 (digit 0 shows C).
- From that state: `bksp` → `char_count` = 7, digit 0 blank, digit 7 shows code 9. `bksp` + `char_valid` together → only backspace applied. `clr` + `bksp` → all blank, `char_count` = 0. `bksp` at `count` 0 → no change.
- BLINK_CYCLES = 4, `keying` = 1 → `seg_data[0]` toggles every 4 cycles. `keying` = 0 → `seg_data[0]` = 0 one edge later. Code 45 → digit 7 = 8'h02.
- Assert `rst` for one cycle mid-blink with `char_valid` high → all outputs 0 after the edge, and the character is not stored.
